// File: rtl/atm_ctrl_multi.sv
// atm_ctrl_multi: card-session controller for an ATM with internally held
// account balances. It handles PIN retries, language choice, withdraw /
// deposit / inquiry with a per-session withdrawal cap, and inactivity timeout.
module atm_ctrl_multi #(
   parameter int BALANCE_WIDTH  = 20,
   parameter int NUM_ACCOUNTS   = 4,
   parameter int ID_WIDTH       = 2,     // must equal $clog2(NUM_ACCOUNTS)
   parameter int MAX_PIN_TRIES  = 3,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int SESSION_LIMIT  = 5000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_en,
   input  logic [ID_WIDTH-1:0]      load_id,
   input  logic [BALANCE_WIDTH-1:0] load_value,
   input  logic                     card_in,
   input  logic [ID_WIDTH-1:0]      account_id,
   input  logic                     pin_valid,
   input  logic                     wrong_psw,
   input  logic                     language,
   input  logic                     op_valid,
   input  logic [1:0]               operation,
   input  logic [BALANCE_WIDTH-1:0] value,
   input  logic                     another_service,
   output logic [BALANCE_WIDTH-1:0] balance,
   output logic                     op_done,
   output logic                     error,
   output logic [2:0]               err_code,
   output logic                     lang_sel,
   output logic                     card_retained,
   output logic                     busy
);

   localparam int TRIES_W = $clog2(MAX_PIN_TRIES + 1);
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SUM_W   = BALANCE_WIDTH + 1;

   localparam logic [TRIES_W-1:0] LAST_TRY   = TRIES_W'(MAX_PIN_TRIES - 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [SUM_W-1:0]   LIMIT      = SUM_W'(SESSION_LIMIT);

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_FUNDS    = 3'd1;
   localparam logic [2:0] ERR_LIMIT    = 3'd2;
   localparam logic [2:0] ERR_OVERFLOW = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
   localparam logic [2:0] ERR_RETAINED = 3'd5;
   localparam logic [2:0] ERR_ILLEGAL  = 3'd6;

   localparam logic [1:0] OP_WITHDRAW = 2'b00;
   localparam logic [1:0] OP_DEPOSIT  = 2'b01;
   localparam logic [1:0] OP_INQUIRY  = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      AUTH,
      LANG,
      SELECT,
      EXEC,
      DONE,
      EJECT,
      RETAIN
   } state_t;

   state_t                   state_q, state_d;
   logic [ID_WIDTH-1:0]      acct_q, acct_d;
   logic [TRIES_W-1:0]       tries_q, tries_d;
   logic [TIMER_W-1:0]       timer_q, timer_d;
   logic [BALANCE_WIDTH-1:0] sessionTotal_q, sessionTotal_d;
   logic [1:0]               op_q, op_d;
   logic [BALANCE_WIDTH-1:0] value_q, value_d;
   logic [BALANCE_WIDTH-1:0] balance_q, balance_d;
   logic                     opDone_q, opDone_d;
   logic                     error_q, error_d;
   logic [2:0]               errCode_q, errCode_d;
   logic                     langSel_q, langSel_d;

   logic [BALANCE_WIDTH-1:0] balances_q [NUM_ACCOUNTS];

   logic                     wrEn;
   logic [ID_WIDTH-1:0]      wrIdx;
   logic [BALANCE_WIDTH-1:0] wrData;

   logic [BALANCE_WIDTH-1:0] selBalance;
   logic [SUM_W-1:0]         depositSum;
   logic [SUM_W-1:0]         sessionSum;
   logic                     strobe;
   logic                     counting;
   logic                     sessionActive;
   logic                     timeoutHit;

   assign selBalance    = balances_q[acct_q];
   assign depositSum    = {1'b0, selBalance} + {1'b0, value_q};
   assign sessionSum    = {1'b0, sessionTotal_q} + {1'b0, value_q};
   assign strobe        = pin_valid | op_valid;
   assign counting      = (state_q == AUTH) || (state_q == LANG) ||
                          (state_q == SELECT) || (state_q == DONE);
   assign sessionActive = counting || (state_q == EXEC);
   assign timeoutHit    = counting && !strobe && (timer_q == TIMER_LAST);

   // Next-state, session bookkeeping and the registered output values.
   always_comb begin
      state_d        = state_q;
      acct_d         = acct_q;
      tries_d        = tries_q;
      timer_d        = timer_q;
      sessionTotal_d = sessionTotal_q;
      op_d           = op_q;
      value_d        = value_q;
      balance_d      = balance_q;
      opDone_d       = 1'b0;
      error_d        = 1'b0;
      errCode_d      = errCode_q;
      langSel_d      = langSel_q;
      wrEn           = 1'b0;
      wrIdx          = acct_q;
      wrData         = selBalance;

      case (state_q)
         IDLE: begin
            if (load_en) begin
               wrEn   = 1'b1;
               wrIdx  = load_id;
               wrData = load_value;
            end
            if (card_in) begin
               state_d = AUTH;
               acct_d  = account_id;
               tries_d = '0;
            end
         end
         AUTH: begin
            if (pin_valid) begin
               if (!wrong_psw) begin
                  state_d = LANG;
               end else begin
                  tries_d = tries_q + TRIES_W'(1);
                  error_d = 1'b1;
                  if (tries_q == LAST_TRY) begin
                     state_d   = RETAIN;
                     errCode_d = ERR_RETAINED;
                  end else begin
                     errCode_d = ERR_NONE;
                  end
               end
            end
         end
         LANG: begin
            if (op_valid) begin
               langSel_d = language;
               state_d   = SELECT;
            end
         end
         SELECT: begin
            if (op_valid) begin
               op_d    = operation;
               value_d = value;
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d   = DONE;
            balance_d = selBalance;
            case (op_q)
               OP_WITHDRAW: begin
                  if (value_q > selBalance) begin
                     error_d   = 1'b1;
                     errCode_d = ERR_FUNDS;
                  end else if (sessionSum > LIMIT) begin
                     error_d   = 1'b1;
                     errCode_d = ERR_LIMIT;
                  end else begin
                     wrEn           = 1'b1;
                     wrData         = selBalance - value_q;
                     balance_d      = selBalance - value_q;
                     sessionTotal_d = sessionTotal_q + value_q;
                     opDone_d       = 1'b1;
                     errCode_d      = ERR_NONE;
                  end
               end
               OP_DEPOSIT: begin
                  if (depositSum[BALANCE_WIDTH]) begin
                     error_d   = 1'b1;
                     errCode_d = ERR_OVERFLOW;
                  end else begin
                     wrEn      = 1'b1;
                     wrData    = depositSum[BALANCE_WIDTH-1:0];
                     balance_d = depositSum[BALANCE_WIDTH-1:0];
                     opDone_d  = 1'b1;
                     errCode_d = ERR_NONE;
                  end
               end
               OP_INQUIRY: begin
                  opDone_d  = 1'b1;
                  errCode_d = ERR_NONE;
               end
               default: begin
                  error_d   = 1'b1;
                  errCode_d = ERR_ILLEGAL;
               end
            endcase
         end
         DONE: begin
            if (op_valid) begin
               state_d = another_service ? SELECT : EJECT;
            end
         end
         EJECT: begin
            if (!card_in) begin
               state_d = IDLE;
            end
         end
         RETAIN: begin
            state_d = RETAIN;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (timeoutHit) begin
         state_d   = EJECT;
         error_d   = 1'b1;
         errCode_d = ERR_TIMEOUT;
      end

      // Pulling the card aborts silently; an EXEC result already computed
      // this cycle still stands.
      if (sessionActive && !card_in) begin
         state_d = IDLE;
         if (state_q != EXEC) begin
            error_d   = 1'b0;
            errCode_d = errCode_q;
         end
      end

      if (!counting || strobe || (state_d != state_q)) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TIMER_W'(1);
      end

      if ((state_d == IDLE) && (state_q != IDLE)) begin
         sessionTotal_d = '0;
      end
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= IDLE;
         acct_q         <= '0;
         tries_q        <= '0;
         timer_q        <= '0;
         sessionTotal_q <= '0;
         op_q           <= '0;
         value_q        <= '0;
         balance_q      <= '0;
         opDone_q       <= 1'b0;
         error_q        <= 1'b0;
         errCode_q      <= ERR_NONE;
         langSel_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         acct_q         <= acct_d;
         tries_q        <= tries_d;
         timer_q        <= timer_d;
         sessionTotal_q <= sessionTotal_d;
         op_q           <= op_d;
         value_q        <= value_d;
         balance_q      <= balance_d;
         opDone_q       <= opDone_d;
         error_q        <= error_d;
         errCode_q      <= errCode_d;
         langSel_q      <= langSel_d;
      end
   end

   // Account balance storage: loaded from outside in IDLE, updated by EXEC.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            balances_q[i] <= '0;
         end
      end else if (wrEn) begin
         balances_q[wrIdx] <= wrData;
      end
   end

   assign balance       = balance_q;
   assign op_done       = opDone_q;
   assign error         = error_q;
   assign err_code      = errCode_q;
   assign lang_sel      = langSel_q;
   assign card_retained = (state_q == RETAIN);
   assign busy          = (state_q != IDLE);

endmodule
